i2c_write_arbiter: RTL and testbench

I2C_WRITE_ARBITER -- requirements
Module: i2c_write_arbiter

---
 rtl/i2c_write_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_i2c_write_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter
// Shares one I2C master between four write requesters using round-robin
// arbitration with a rotating priority pointer. Each grant performs one
// single-byte write: the winner's address/data are latched, a start strobe
// is held low until the master reports busy, and completion (with an error
// flag for NACK or launch timeout) is returned as a one-cycle done pulse.
//
// Build option: define I2C_ARB_WDOG_EN to compile in a BUSY watchdog that
// pulses m_reset low for two cycles and fails the transfer when the master
// stays busy for WDOG_CYC cycles. Without the macro, BUSY waits forever.
module i2c_write_arbiter #(
  parameter int LAUNCH_TO = 8,
  parameter int WDOG_CYC  = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [27:0] req_addr,
  input  logic [31:0] req_data,
  output logic [3:0]  done,
  output logic [3:0]  err,
  output logic        busy,
  output logic [6:0]  m_addr,
  output logic [7:0]  m_data_tx,
  output logic        m_start,
  input  logic        m_ready,
  input  logic        m_ack_fail,
  output logic        m_reset
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Last LAUNCH count value before giving up on the master.
  localparam logic [3:0] LAUNCH_LAST = 4'(LAUNCH_TO - 1);

  // Rotating-priority pick: first set request at or after the pointer.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v,
                                         input logic [1:0] ptr_v);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr_v;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_v + 2'(k);
      if (!found && req_v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [3:0] onehot(input logic [1:0] g);
    case (g)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
  endfunction

  // Slave address slice belonging to requester g.
  function automatic logic [6:0] addr_of(input logic [27:0] a,
                                         input logic [1:0]  g);
    case (g)
      2'd0:    addr_of = a[6:0];
      2'd1:    addr_of = a[13:7];
      2'd2:    addr_of = a[20:14];
      2'd3:    addr_of = a[27:21];
      default: addr_of = a[6:0];
    endcase
  endfunction

  // Data byte slice belonging to requester g.
  function automatic logic [7:0] data_of(input logic [31:0] d,
                                         input logic [1:0]  g);
    case (g)
      2'd0:    data_of = d[7:0];
      2'd1:    data_of = d[15:8];
      2'd2:    data_of = d[23:16];
      2'd3:    data_of = d[31:24];
      default: data_of = d[7:0];
    endcase
  endfunction

  state_t     state_r,      state_s;
  logic [1:0] ptr_r,        ptr_s;
  logic [1:0] grant_r,      grant_s;
  logic [3:0] launch_cnt_r, launch_cnt_s;
  logic       nack_r,       nack_s;
  logic       timeout_r,    timeout_s;
  logic [3:0] done_r,       done_s;
  logic [3:0] err_r,        err_s;
  logic       busy_r,       busy_s;
  logic [6:0] m_addr_r,     m_addr_s;
  logic [7:0] m_data_r,     m_data_s;
  logic       m_start_r,    m_start_s;
  logic [1:0] pick_s;
  logic [3:0] grant_oh_s;

`ifdef I2C_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

  logic [WDOG_W-1:0] wdog_cnt_r,   wdog_cnt_s;
  logic [1:0]        wdog_pulse_r, wdog_pulse_s;
`endif

  assign pick_s     = rr_pick(req, ptr_r);
  assign grant_oh_s = onehot(grant_r);

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    grant_s      = grant_r;
    launch_cnt_s = launch_cnt_r;
    nack_s       = nack_r;
    timeout_s    = timeout_r;
    done_s       = 4'b0000;
    err_s        = 4'b0000;
    m_addr_s     = m_addr_r;
    m_data_s     = m_data_r;
    m_start_s    = 1'b1;
`ifdef I2C_ARB_WDOG_EN
    wdog_cnt_s   = wdog_cnt_r;
    wdog_pulse_s = (wdog_pulse_r != 2'd0) ? (wdog_pulse_r - 2'd1) : 2'd0;
`endif

    case (state_r)
      IDLE: begin
        if (m_ready && (req != 4'b0000)) begin
          grant_s      = pick_s;
          ptr_s        = pick_s + 2'd1;
          m_addr_s     = addr_of(req_addr, pick_s);
          m_data_s     = data_of(req_data, pick_s);
          m_start_s    = 1'b0;
          launch_cnt_s = 4'd0;
          state_s      = LAUNCH;
        end else begin
          state_s = IDLE;
        end
      end

      LAUNCH: begin
        if (!m_ready) begin
          // Master has accepted the start; release the strobe on this edge.
          m_start_s = 1'b1;
          state_s   = BUSY;
        end else if (launch_cnt_r >= LAUNCH_LAST) begin
          // Master never went busy: fail the transfer.
          timeout_s = 1'b1;
          done_s    = grant_oh_s;
          err_s     = grant_oh_s;
          state_s   = FINISH;
        end else begin
          m_start_s    = 1'b0;
          launch_cnt_s = (launch_cnt_r == 4'hF) ? 4'hF : (launch_cnt_r + 4'd1);
        end
      end

      BUSY: begin
        // A NACK pulse can be a single cycle, so capture it sticky.
        nack_s = nack_r | ~m_ack_fail;
        if (m_ready) begin
          done_s  = grant_oh_s;
          err_s   = grant_oh_s & {4{nack_s | timeout_r}};
          state_s = FINISH;
        end
`ifdef I2C_ARB_WDOG_EN
        else if (wdog_cnt_r >= WDOG_LAST) begin
          done_s       = grant_oh_s;
          err_s        = grant_oh_s;
          wdog_pulse_s = 2'd2;
          state_s      = FINISH;
        end else begin
          wdog_cnt_s = wdog_cnt_r + WDOG_W'(1);
        end
`else
        else begin
          state_s = BUSY;
        end
`endif
      end

      FINISH: begin
        nack_s       = 1'b0;
        timeout_s    = 1'b0;
        launch_cnt_s = 4'd0;
`ifdef I2C_ARB_WDOG_EN
        wdog_cnt_s   = '0;
`endif
        state_s      = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State, pointer and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      ptr_r        <= 2'd0;
      grant_r      <= 2'd0;
      launch_cnt_r <= 4'd0;
      nack_r       <= 1'b0;
      timeout_r    <= 1'b0;
      done_r       <= 4'b0000;
      err_r        <= 4'b0000;
      busy_r       <= 1'b0;
      m_addr_r     <= 7'd0;
      m_data_r     <= 8'd0;
      m_start_r    <= 1'b1;
`ifdef I2C_ARB_WDOG_EN
      wdog_cnt_r   <= '0;
      wdog_pulse_r <= 2'd0;
`endif
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      grant_r      <= grant_s;
      launch_cnt_r <= launch_cnt_s;
      nack_r       <= nack_s;
      timeout_r    <= timeout_s;
      done_r       <= done_s;
      err_r        <= err_s;
      busy_r       <= busy_s;
      m_addr_r     <= m_addr_s;
      m_data_r     <= m_data_s;
      m_start_r    <= m_start_s;
`ifdef I2C_ARB_WDOG_EN
      wdog_cnt_r   <= wdog_cnt_s;
      wdog_pulse_r <= wdog_pulse_s;
`endif
    end
  end

  assign done      = done_r;
  assign err       = err_r;
  assign busy      = busy_r;
  assign m_addr    = m_addr_r;
  assign m_data_tx = m_data_r;
  assign m_start   = m_start_r;

  // Master reset tracks our reset directly so a mid-transfer reset also
  // returns the master to idle; the watchdog can additionally pulse it.
`ifdef I2C_ARB_WDOG_EN
  assign m_reset = reset & ~(wdog_pulse_r != 2'd0);
`else
  assign m_reset = reset;
`endif

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Directed testbench for i2c_write_arbiter (default build, no watchdog).
// A small behavioural I2C master is driven from the stimulus tasks.
module tb_i2c_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [27:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  done;
  logic [3:0]  err;
  logic        busy;
  logic [6:0]  m_addr;
  logic [7:0]  m_data_tx;
  logic        m_start;
  logic        m_ready;
  logic        m_ack_fail;
  logic        m_reset;

  int n_cmp = 0;
  int n_bad = 0;

  logic [27:0] addr_vec;
  logic [31:0] data_vec;

  i2c_write_arbiter #(.LAUNCH_TO(8), .WDOG_CYC(127)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .m_addr     (m_addr),
    .m_data_tx  (m_data_tx),
    .m_start    (m_start),
    .m_ready    (m_ready),
    .m_ack_fail (m_ack_fail),
    .m_reset    (m_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer as seen by the master model; idx is the expected winner.
  task automatic serve(input int idx, input int busy_len, input int nack_at,
                       input logic exp_err, input logic [3:0] clr_mask,
                       input logic scramble);
    int         waited;
    logic [3:0] oh;
    logic [6:0] ea;
    logic [7:0] ed;
    oh = 4'b0001 << idx;
    ea = addr_vec[7*idx +: 7];
    ed = data_vec[8*idx +: 8];
    waited = 0;
    while (m_start !== 1'b0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check("start_low", 32'(m_start), 32'd0);
    check("m_addr", 32'(m_addr), 32'(ea));
    check("m_data_tx", 32'(m_data_tx), 32'(ed));
    check("busy_launch", 32'(busy), 32'd1);
    m_ready = 1'b0;
    @(negedge clk);
    check("start_release", 32'(m_start), 32'd1);
    for (int i = 0; i < busy_len; i++) begin
      m_ack_fail = (i == nack_at) ? 1'b0 : 1'b1;
      if (scramble) begin
        req_addr = ~addr_vec;
        req_data = ~data_vec;
      end else begin
        req_addr = addr_vec;
      end
      @(negedge clk);
    end
    m_ack_fail = 1'b1;
    m_ready    = 1'b1;
    @(negedge clk);
    check("done", 32'(done), 32'(oh));
    check("err", 32'(err), exp_err ? 32'(oh) : 32'd0);
    check("addr_hold", 32'(m_addr), 32'(ea));
    check("data_hold", 32'(m_data_tx), 32'(ed));
    req_addr = addr_vec;
    req_data = data_vec;
    req = req & ~clr_mask;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int cnt;
    addr_vec   = {7'h43, 7'h32, 7'h21, 7'h50};
    data_vec   = {8'h33, 8'h22, 8'h11, 8'hA5};
    reset      = 1'b0;
    req        = 4'b0000;
    req_addr   = addr_vec;
    req_data   = data_vec;
    m_ready    = 1'b1;
    m_ack_fail = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_start", 32'(m_start), 32'd1);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_m_data", 32'(m_data_tx), 32'd0);
    check("rst_m_reset", 32'(m_reset), 32'd0);
    reset = 1'b1;
    #1;
    check("m_reset_follow", 32'(m_reset), 32'd1);
    @(negedge clk);

    // All four requesting, held: order 0,1,2,3,0
    req = 4'b1111;
    serve(0, 2, -1, 1'b0, 4'b0000, 1'b0);
    serve(1, 3, -1, 1'b0, 4'b0000, 1'b0);
    serve(2, 1, -1, 1'b0, 4'b0000, 1'b0);
    serve(3, 2, -1, 1'b0, 4'b0000, 1'b0);
    serve(0, 2, -1, 1'b0, 4'b1111, 1'b0);
    check("idle_after_rr", 32'(busy), 32'd0);

    // Pointer at 1: req 1001 grants 3; bit 0 dropped before grant is ignored
    req = 4'b1001;
    serve(3, 2, -1, 1'b0, 4'b1001, 1'b0);
    repeat (5) @(negedge clk);
    check("dropped_req_ignored", 32'(busy), 32'd0);

    // Single write with ACK, inputs scrambled during transfer
    req = 4'b0001;
    serve(0, 3, -1, 1'b0, 4'b0001, 1'b1);

    // One-cycle NACK on requester 2
    req = 4'b0100;
    serve(2, 4, 1, 1'b1, 4'b0100, 1'b0);

    // Master never starts: 8-cycle launch then timeout error
    req = 4'b0010;
    cnt = 0;
    while (m_start !== 1'b0 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (m_start === 1'b0 && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    check("launch_len", 32'(cnt), 32'd8);
    check("to_done", 32'(done), 32'b0010);
    check("to_err", 32'(err), 32'b0010);
    req = 4'b0000;
    @(negedge clk);
    check("to_done_pulse", 32'(done), 32'd0);

    // Reset in the 20th BUSY cycle
    req = 4'b0001;
    cnt = 0;
    while (m_start !== 1'b0 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_xfer_start", 32'(m_start), 32'd0);
    m_ready = 1'b0;
    @(negedge clk);
    repeat (19) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("m_reset_mid", 32'(m_reset), 32'd0);
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_m_start", 32'(m_start), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    reset   = 1'b1;
    req     = 4'b0000;
    m_ready = 1'b1;
    @(negedge clk);

    // Pointer back at 0 after reset: 1111 grants 0 first
    req = 4'b1111;
    serve(0, 2, -1, 1'b0, 4'b1111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
